shift_register_seq: RTL and testbench



---
 rtl/shift_pkg.sv | 26 ++
 rtl/shift_register_seq_if.sv | 18 +
 rtl/shift_bit_mux.sv | 33 +++
 rtl/shift_register_seq.sv | 105 ++++++++++
 tb/tb_shift_register_seq.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// Shared types for the universal shift register: operation codes, sequencer
// states and a helper that classifies multi-step operations.
package shift_pkg;

  typedef enum logic [2:0] {
    HOLD = 3'd0,
    SHR  = 3'd1,
    SHL  = 3'd2,
    LOAD = 3'd3,
    ROR  = 3'd4,
    ROL  = 3'd5,
    ASR  = 3'd6
  } op_t;

  localparam logic [2:0] OP_RESERVED = 3'd7;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic is_shift(op_t o);
    return o inside {SHR, SHL, ROR, ROL, ASR};
  endfunction

endpackage

// File: rtl/shift_register_seq_if.sv
// Control/data bundle between a datapath client and the shift register.
interface shift_register_seq_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = $clog2(WIDTH) + 1
);
  logic [2:0]       op;
  logic [WIDTH-1:0] d;
  logic             i;
  logic             go;
  logic [AW-1:0]    amt;
  logic [WIDTH-1:0] q;
  logic             so;
  logic             busy;
  logic             done;

  modport master (output op, d, i, go, amt, input q, so, busy, done);
  modport slave  (input op, d, i, go, amt, output q, so, busy, done);
endinterface

// File: rtl/shift_bit_mux.sv
// Next-state selector for one register bit; end bits take the serial input or
// keep their value (ASR sign) depending on their position.
module shift_bit_mux
  import shift_pkg::*;
#(
  parameter bit IS_MSB = 1'b0,
  parameter bit IS_LSB = 1'b0
) (
  input  op_t  op_i,
  input  logic hold_i,
  input  logic left_i,
  input  logic right_i,
  input  logic load_i,
  input  logic ser_i,
  output logic bit_o
);

  // left_i is the next-higher bit (wraps to bit 0 at the MSB),
  // right_i the next-lower bit (wraps to the MSB at bit 0)
  always_comb begin
    bit_o = hold_i;
    case (op_i)
      SHR:     bit_o = IS_MSB ? ser_i : left_i;
      ROR:     bit_o = left_i;
      ASR:     bit_o = IS_MSB ? hold_i : left_i;
      SHL:     bit_o = IS_LSB ? ser_i : right_i;
      ROL:     bit_o = right_i;
      LOAD:    bit_o = load_i;
      default: bit_o = hold_i;
    endcase
  end

endmodule

// File: rtl/shift_register_seq.sv
// WIDTH-generic universal shift register with a go/amt sequencer that applies
// a captured shift or rotate one position per clock.
module shift_register_seq
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = $clog2(WIDTH) + 1
) (
  input logic                c,
  input logic                nrst,
  shift_register_seq_if.slave bus
);

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  op_t              op_live, step_op;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             so_q, so_d;
  logic             done_q, done_d;

  assign op_live = op_t'(bus.op);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    step_op = HOLD;
    case (state_q)
      IDLE: begin
        if (bus.go) begin
          // a go never moves q on its own edge except for a LOAD request
          step_op = (op_live == LOAD) ? LOAD : HOLD;
          if (is_shift(op_live) && (bus.amt != '0)) begin
            state_d = RUN;
            op_d    = op_live;
            cnt_d   = bus.amt;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          step_op = op_live;
        end
      end
      RUN: begin
        step_op = op_q;
        cnt_d   = cnt_q - AW'(1);
        if (cnt_q == AW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    so_d = so_q;
    case (step_op)
      SHR, ROR, ASR: so_d = q_q[0];
      SHL, ROL:      so_d = q_q[WIDTH-1];
      default:       so_d = so_q;
    endcase
  end

  for (genvar k = 0; k < WIDTH; k++) begin : g_bit
    shift_bit_mux #(
      .IS_MSB(k == WIDTH - 1),
      .IS_LSB(k == 0)
    ) u_mux (
      .op_i   (step_op),
      .hold_i (q_q[k]),
      .left_i (q_q[(k + 1) % WIDTH]),
      .right_i(q_q[(k + WIDTH - 1) % WIDTH]),
      .load_i (bus.d[k]),
      .ser_i  (bus.i),
      .bit_o  (q_d[k])
    );
  end

  always_ff @(posedge c or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      op_q    <= HOLD;
      cnt_q   <= '0;
      q_q     <= '0;
      so_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      so_q    <= so_d;
      done_q  <= done_d;
    end
  end

  assign bus.q    = q_q;
  assign bus.so   = so_q;
  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;

endmodule

// File: tb/tb_shift_register_seq.sv
// Directed bench for shift_register_seq (WIDTH=8): expectations are queued as
// each step is driven and compared after the following clock edge.
module tb_shift_register_seq;
  import shift_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned AW = $clog2(W) + 1;

  logic c = 1'b0;
  logic nrst;
  always #5 c = ~c;

  shift_register_seq_if #(.WIDTH(W)) bus ();
  shift_register_seq #(.WIDTH(W)) dut (.c(c), .nrst(nrst), .bus(bus));

  typedef struct {
    string        tag;
    logic [W-1:0] q;
    logic         so;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t sb[$];
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  int unsigned n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [W-1:0] d, input logic i,
                       input logic go, input logic [AW-1:0] amt);
    bus.op  = op;
    bus.d   = d;
    bus.i   = i;
    bus.go  = go;
    bus.amt = amt;
  endtask

  task automatic sb_push(input string tag, input logic [W-1:0] q, input logic so,
                         input logic busy, input logic done);
    exp_t e;
    e.tag  = tag;
    e.q    = q;
    e.so   = so;
    e.busy = busy;
    e.done = done;
    sb.push_back(e);
  endtask

  task automatic check_head();
    exp_t e;
    if (sb.size() == 0) begin
      n_total++;
      n_fail++;
      $error("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".q"},    32'(bus.q),    32'(e.q));
      chk({e.tag, ".so"},   32'(bus.so),   32'(e.so));
      chk({e.tag, ".busy"}, 32'(bus.busy), 32'(e.busy));
      chk({e.tag, ".done"}, 32'(bus.done), 32'(e.done));
    end
  endtask

  task automatic cycle();
    @(posedge c);
    #1;
    check_head();
  endtask

  task automatic step(input logic [2:0] op, input logic [W-1:0] d, input logic i,
                      input logic go, input logic [AW-1:0] amt, input string tag,
                      input logic [W-1:0] q, input logic so, input logic busy,
                      input logic done);
    drive(op, d, i, go, amt);
    sb_push(tag, q, so, busy, done);
    cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] x;
    logic         s;

    nrst = 1'b1;
    drive(3'(HOLD), '0, 1'b0, 1'b0, '0);
    #2 nrst = 1'b0;
    #1;
    sb_push("reset0", 8'h00, 1'b0, 1'b0, 1'b0);
    check_head();
    repeat (2) @(posedge c);
    #1 nrst = 1'b1;

    // asynchronous reset from a non-zero state, checked mid-cycle
    step(3'(LOAD), 8'h5B, 1'b0, 1'b0, '0, "pre_load", 8'h5B, 1'b0, 1'b0, 1'b0);
    step(3'(SHR),  8'h00, 1'b1, 1'b0, '0, "pre_shr",  8'hAD, 1'b1, 1'b0, 1'b0);
    #3 nrst = 1'b0;
    #1;
    sb_push("async_rst", 8'h00, 1'b0, 1'b0, 1'b0);
    check_head();
    drive(3'(HOLD), '0, 1'b0, 1'b0, '0);
    @(posedge c);
    #1 nrst = 1'b1;

    // single-step operations
    step(3'(LOAD), 8'hA5, 1'b0, 1'b0, '0, "load_a5", 8'hA5, 1'b0, 1'b0, 1'b0);
    step(3'(SHR),  8'h00, 1'b1, 1'b0, '0, "shr_i1",  8'hD2, 1'b1, 1'b0, 1'b0);
    step(3'(SHL),  8'h00, 1'b0, 1'b0, '0, "shl_i0",  8'hA4, 1'b1, 1'b0, 1'b0);
    step(3'(LOAD), 8'h81, 1'b0, 1'b0, '0, "load_81", 8'h81, 1'b1, 1'b0, 1'b0);
    step(3'(ROL),  8'h00, 1'b0, 1'b0, '0, "rol",     8'h03, 1'b1, 1'b0, 1'b0);
    step(3'(LOAD), 8'h80, 1'b0, 1'b0, '0, "load_80", 8'h80, 1'b1, 1'b0, 1'b0);
    step(3'(ASR),  8'h00, 1'b0, 1'b0, '0, "asr",     8'hC0, 1'b0, 1'b0, 1'b0);
    step(OP_RESERVED, 8'h3C, 1'b1, 1'b0, '0, "rsvd", 8'hC0, 1'b0, 1'b0, 1'b0);
    step(3'(HOLD), 8'h3C, 1'b1, 1'b0, '0, "hold",    8'hC0, 1'b0, 1'b0, 1'b0);

    // go ROR amt=3, with a LOAD request during the run
    step(3'(LOAD), 8'h01, 1'b0, 1'b0, '0, "load_01", 8'h01, 1'b0, 1'b0, 1'b0);
    step(3'(ROR),  8'h00, 1'b0, 1'b1, AW'(3), "ror3_e0", 8'h01, 1'b0, 1'b1, 1'b0);
    step(3'(LOAD), 8'hFF, 1'b0, 1'b1, AW'(1), "ror3_e1", 8'h80, 1'b1, 1'b1, 1'b0);
    step(3'(LOAD), 8'hFF, 1'b0, 1'b0, '0,     "ror3_e2", 8'h40, 1'b0, 1'b1, 1'b0);
    step(3'(LOAD), 8'hFF, 1'b0, 1'b0, '0,     "ror3_e3", 8'h20, 1'b0, 1'b0, 1'b1);

    // go with amt=0 issued in the done cycle
    step(3'(ROR),  8'h00, 1'b0, 1'b1, '0, "amt0",      8'h20, 1'b0, 1'b0, 1'b1);
    step(3'(LOAD), 8'h00, 1'b1, 1'b0, '0, "load_00",   8'h00, 1'b0, 1'b0, 1'b0);

    // shift by the full width fills from i
    step(3'(SHL),  8'h00, 1'b1, 1'b1, AW'(8), "shl8_e0", 8'h00, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      x = 8'((16'd1 << k) - 16'd1);
      step(3'(HOLD), 8'h00, 1'b1, 1'b0, '0, $sformatf("shl8_e%0d", k),
           x, 1'b0, (k < 8), (k == 8));
    end
    chk("shl8_full", 32'(bus.q), 32'hFF);

    // rotate by WIDTH returns the original word
    step(3'(LOAD), 8'h96, 1'b0, 1'b0, '0, "load_96", 8'h96, 1'b0, 1'b0, 1'b0);
    step(3'(ROL),  8'h00, 1'b0, 1'b1, AW'(8), "rol8_e0", 8'h96, 1'b0, 1'b1, 1'b0);
    x = 8'h96;
    s = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      s = x[7];
      x = {x[6:0], x[7]};
      step(3'(HOLD), 8'h00, 1'b0, 1'b0, '0, $sformatf("rol8_e%0d", k),
           x, s, (k < 8), (k == 8));
    end
    chk("rol8_orig", 32'(bus.q), 32'h96);

    // multi-step arithmetic shift keeps the sign
    step(3'(LOAD), 8'h90, 1'b0, 1'b0, '0, "load_90", 8'h90, s, 1'b0, 1'b0);
    step(3'(ASR),  8'h00, 1'b0, 1'b1, AW'(3), "asr3_e0", 8'h90, s, 1'b1, 1'b0);
    x = 8'h90;
    for (int k = 1; k <= 3; k++) begin
      s = x[0];
      x = {x[7], x[7:1]};
      step(3'(SHL), 8'h00, 1'b1, 1'b0, '0, $sformatf("asr3_e%0d", k),
           x, s, (k < 3), (k == 3));
    end
    step(3'(HOLD), 8'h00, 1'b0, 1'b0, '0, "asr3_idle", 8'hF2, 1'b0, 1'b0, 1'b0);

    // abort a run with reset
    step(3'(LOAD), 8'h01, 1'b0, 1'b0, '0, "load_01b", 8'h01, 1'b0, 1'b0, 1'b0);
    step(3'(ROR),  8'h00, 1'b0, 1'b1, AW'(5), "abort_e0", 8'h01, 1'b0, 1'b1, 1'b0);
    step(3'(ROR),  8'h00, 1'b0, 1'b0, '0, "abort_e1", 8'h80, 1'b1, 1'b1, 1'b0);
    step(3'(ROR),  8'h00, 1'b0, 1'b0, '0, "abort_e2", 8'h40, 1'b0, 1'b1, 1'b0);
    #3 nrst = 1'b0;
    #1;
    sb_push("abort_rst", 8'h00, 1'b0, 1'b0, 1'b0);
    check_head();
    drive(3'(HOLD), '0, 1'b0, 1'b0, '0);
    @(posedge c);
    #1 nrst = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step(3'(HOLD), 8'h00, 1'b0, 1'b0, '0, $sformatf("abort_after%0d", k),
           8'h00, 1'b0, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
